des_core: RTL and testbench
===========================

# des_core

Iterative DES block cipher engine (FIPS 46-3) with run-time encrypt/decrypt mode selection and a compile-time rounds-per-cycle unroll factor. It supersedes the fixed single-mode DES block in the image-encryption datapath. It accepts one 64-bit block and one 64-bit key per operation, runs the full 16-round Feistel network, and holds the result under a done/ack handshake until the image pipeline consumes it.

## Interface
- ROUNDS_PER_CYCLE, 1, number of Feistel rounds evaluated per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- decrypt  in  1  mode; 0 = encrypt, 1 = decrypt; sampled with start.
- key_in  in  64  DES key, sampled with start; parity bits (DES bits 8, 16, …, 64) are ignored.
- data_in  in  64  plaintext or ciphertext block, sampled with start.
- busy  out  1  high while rounds are in progress.
- done  out  1  result valid; held until ack.
- data_out  out  64  result block; registered.
- ack  in  1  consumer acknowledge; honoured only while done is high.

## Operation
- Bit numbering: DES bit 1 is word bit 63, and DES bit 64 is word bit 0. This applies to all permutation tables (IP, FP, PC-1, PC-2, E, P) and to the S-box inputs and outputs.
- States:
  - IDLE: start=1 → LOAD actions, go to ROUND.
  - ROUND: go to DONE after 16/ROUNDS_PER_CYCLE cycles.
  - DONE: ack=1 → IDLE.
- LOAD edge (start accepted in IDLE):
  - L‖R ← IP(data_in).
  - C‖D ← PC-1(key_in).
  - The mode bit is latched.
  - The round counter is cleared.
- Each ROUND cycle applies ROUNDS_PER_CYCLE chained rounds combinationally:
  - L' = R.
  - R' = L xor P(S(E(R) xor K)).
  - The counter advances by ROUNDS_PER_CYCLE. The counter is 5 bits; it never wraps because the exit is taken when it reaches 16.
- Key schedule, encrypt: before round i, rotate C and D left by 1 for i ∈ {1, 2, 9, 16} and by 2 otherwise. Then K = PC-2(C‖D).
- Key schedule, decrypt: round 1 uses PC-2 of the unrotated C‖D. Before rounds 2, 9 and 16, rotate right by 1. Before all other rounds, rotate right by 2. This yields K16..K1 in order.
- Final ROUND edge:
  - data_out ← FP(R16‖L16), i.e. the halves are swapped before FP.
  - The state goes to DONE.
- Once start is accepted, the block does not resample key_in, data_in or decrypt; changes to those inputs during ROUND have no effect.
- Ignored inputs:
  - start in ROUND or DONE is ignored and is not queued.
  - ack outside DONE is ignored.
  - start and ack both high in DONE: ack is honoured and start is dropped. The requester re-presents start in IDLE.
- data_out keeps the last result through IDLE and the next ROUND. It changes only on a final-round edge or on reset.

## Timing
- Reset values: state IDLE, busy=0, done=0, data_out=64'h0. The internal L, R, C, D registers and the counter are cleared.
- Reset asserted during ROUND or DONE aborts the operation immediately. No result is produced.
- Outputs are decoded from registered state:
  - busy = (state==ROUND).
  - done = (state==DONE).
- Latency (N = 16/ROUNDS_PER_CYCLE):
  - start is sampled at edge E0.
  - busy is high from E0 to E0+N.
  - done and data_out are valid after edge E0+N.
  - With ROUNDS_PER_CYCLE=1 the latency is 16 cycles; with 16 it is 1 cycle.
- Throughput is one block per N+2 cycles, assuming ack is returned in the first DONE cycle and start is re-asserted in the following IDLE cycle.
- ack sampled high in DONE at edge Ea: done is low after Ea, and start is accepted no earlier than Ea+1.
- The critical path is ROUNDS_PER_CYCLE chained f-functions. The key schedule must keep pace with it, advancing ROUNDS_PER_CYCLE rounds per cycle.

## Test plan
- Encrypt, key 133457799BBCDFF1, data 0123456789ABCDEF → data_out 85E813540F0AB405. done rises exactly 16 cycles after the start edge with ROUNDS_PER_CYCLE=1.
- Decrypt, same key, data 85E813540F0AB405 → 0123456789ABCDEF.
- Encrypt, key 0E329232EA6D0D73, data 8787878787878787 → 0000000000000000. Then encrypt key 0, data 0 → 8CA64DE9C1B123A7.
- Repeat the first three vectors for ROUNDS_PER_CYCLE = 2, 4, 8 and 16. Results must be identical; latency must be 8, 4, 2 and 1 cycles respectively.
- Handshake:
  - Toggle start, data_in and key_in during ROUND: result unchanged.
  - Hold done without ack for 50 cycles: data_out stable.
  - Assert start and ack together in DONE: return to IDLE and no new operation starts.
- Assert reset at round 7: busy=0, done=0 and data_out=0 immediately. Then run the first vector again → correct result.

Source files
------------

// File: rtl/des_core.sv
// Iterative DES engine: encrypt/decrypt selected per operation, ROUNDS_PER_CYCLE
// Feistel rounds per clock, result held under a done/ack handshake.
module des_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] data_out,
  input  logic        ack
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("des_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Tables hold DES bit numbers: DES bit 1 is the MSB of each word.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y = '0;
    for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e = '0;
    logic [31:0] s = '0;
    logic [31:0] p = '0;
    logic [5:0]  b;
    for (int unsigned i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
    e = e ^ k;
    for (int unsigned j = 0; j < 8; j++) begin
      b = e[6'(47 - 6 * j) -: 6];
      s[5'(31 - 4 * j) -: 4] = 4'(SBOX[3'(j)][{b[5], b[0], b[4:1]}]);
    end
    for (int unsigned i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
    return p;
  endfunction

  function automatic logic [27:0] f_rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] f_rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  state_t      r_state, w_state_nx;
  logic [31:0] r_l, r_r, w_l, w_r;
  logic [27:0] r_c, r_d, w_c, w_d;
  logic [4:0]  r_cnt, w_idx;
  logic        r_dec, w_one, w_last;
  logic [47:0] w_k;
  logic [63:0] r_out;

  assign w_last   = (r_cnt + 5'(ROUNDS_PER_CYCLE)) == 5'd16;
  assign busy     = (r_state == ROUND);
  assign done     = (r_state == DONE);
  assign data_out = r_out;

  // Decrypt walks the schedule backwards: round 1 uses the loaded C/D, later rounds rotate right.
  always_comb begin
    w_l   = r_l;
    w_r   = r_r;
    w_c   = r_c;
    w_d   = r_d;
    w_idx = '0;
    w_one = 1'b0;
    w_k   = '0;
    for (int unsigned k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      w_idx = r_cnt + 5'(k) + 5'd1;
      w_one = (w_idx == 5'd1) || (w_idx == 5'd2) || (w_idx == 5'd9) || (w_idx == 5'd16);
      if (!r_dec) begin
        w_c = f_rotl(w_c, w_one);
        w_d = f_rotl(w_d, w_one);
      end else if (w_idx != 5'd1) begin
        w_c = f_rotr(w_c, w_one);
        w_d = f_rotr(w_d, w_one);
      end
      w_k = f_pc2({w_c, w_d});
      {w_l, w_r} = {w_r, w_l ^ f_func(w_r, w_k)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_state_nx = ROUND;
      ROUND:   if (w_last) w_state_nx = DONE;
      DONE:    if (ack)    w_state_nx = IDLE;
      default:             w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l   <= '0;
      r_r   <= '0;
      r_c   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_dec <= 1'b0;
      r_out <= '0;
    end else if (r_state == IDLE && start) begin
      {r_l, r_r} <= f_ip(data_in);
      {r_c, r_d} <= f_pc1(key_in);
      r_dec      <= decrypt;
      r_cnt      <= '0;
    end else if (r_state == ROUND) begin
      r_l   <= w_l;
      r_r   <= w_r;
      r_c   <= w_c;
      r_d   <= w_d;
      r_cnt <= r_cnt + 5'(ROUNDS_PER_CYCLE);
      if (w_last) r_out <= f_fp({w_r, w_l});
    end
  end

endmodule

// File: tb/tb_des_core.sv
// Bench for des_core: five instances (1,2,4,8,16 rounds/cycle) against a
// transaction-level DES model plus literal FIPS vectors.
module tb_des_core;
  logic        clk, reset;
  logic [4:0]  start, dec, ack, busy, done;
  logic [63:0] key  [5];
  logic [63:0] din  [5];
  logic [63:0] dout [5];
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 0;
  int          LAT_T [5] = '{16, 8, 4, 2, 1};

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1, P1 = 64'h0123456789ABCDEF, C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K3 = 64'h0E329232EA6D0D73, P3 = 64'h8787878787878787, C3 = 64'h0;
  localparam logic [63:0] CZ = 64'h8CA64DE9C1B123A7;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    des_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .decrypt(dec[g]),
      .key_in(key[g]), .data_in(din[g]), .busy(busy[g]), .done(done[g]),
      .data_out(dout[g]), .ack(ack[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int IP_Q[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                   57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int FP_Q[$]  = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                   36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int E_Q[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int P_Q[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int PC1_Q[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_Q[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Generic table permutation: DES bit n of an inw-bit word is word bit inw-n; result right-aligned.
  function automatic logic [63:0] perm(input logic [63:0] x, input int inw, input int t[$]);
    logic [63:0] y;
    y = '0;
    foreach (t[i]) y = {y[62:0], x[6'(inw - t[i])]};
    return y;
  endfunction

  function automatic logic [31:0] ffn(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] e;
    logic [31:0] s;
    int six, row, col;
    t = perm({32'b0, r}, 32, E_Q);
    e = t[47:0] ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = int'(e[6'(47 - 6 * j) -: 6]);
      row = ((six >> 5) & 1) * 2 + (six & 1);
      col = (six >> 1) & 15;
      s = {s[27:0], 4'(SB[j][row * 16 + col])};
    end
    t = perm({32'b0, s}, 32, P_Q);
    return t[31:0];
  endfunction

  // Whole-block DES: build K1..K16 once, decryption just applies them in reverse.
  function automatic logic [63:0] des_model(input logic [63:0] k, input logic [63:0] d, input logic dc);
    logic [63:0] t;
    logic [27:0] c, dd;
    logic [47:0] ks [16];
    logic [31:0] l, r, nr;
    int sh;
    t = perm(k, 64, PC1_Q);
    c = t[55:28];
    dd = t[27:0];
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      c  = (c << sh) | (c >> (28 - sh));
      dd = (dd << sh) | (dd >> (28 - sh));
      t  = perm({8'b0, c, dd}, 56, PC2_Q);
      ks[i] = t[47:0];
    end
    t = perm(d, 64, IP_Q);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      nr = l ^ ffn(r, dc ? ks[15 - i] : ks[i]);
      l = r;
      r = nr;
    end
    return perm({r, l}, 64, FP_Q);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Transaction-level reference: 0 idle, 1 computing, 2 holding result.
  int          m_st [5];
  int          m_left [5];
  logic [63:0] m_k [5], m_d [5], m_out [5];
  logic        m_dec [5];

  always @(posedge clk or posedge reset) begin
    for (int g = 0; g < 5; g++) begin
      if (reset) begin
        m_st[g] = 0;
        m_out[g] = '0;
      end else if (m_st[g] == 0) begin
        if (start[g]) begin
          m_st[g] = 1;
          m_left[g] = LAT_T[g];
          m_k[g] = key[g];
          m_d[g] = din[g];
          m_dec[g] = dec[g];
        end
      end else if (m_st[g] == 1) begin
        m_left[g]--;
        if (m_left[g] == 0) begin
          m_st[g] = 2;
          m_out[g] = des_model(m_k[g], m_d[g], m_dec[g]);
        end
      end else if (ack[g]) begin
        m_st[g] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("cyc_busy[%0d]", g), 64'(busy[g]), 64'(m_st[g] == 1));
        chk($sformatf("cyc_done[%0d]", g), 64'(done[g]), 64'(m_st[g] == 2));
        chk($sformatf("cyc_dout[%0d]", g), dout[g], m_out[g]);
      end
    end
  end

  task automatic wait_done(input int g, output int cyc);
    cyc = 0;
    while (done[g] !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input int g, input logic [63:0] k, input logic [63:0] d,
                        input logic dc, input logic [63:0] exp_v);
    int cyc;
    @(posedge clk); #1;
    key[g] = k; din[g] = d; dec[g] = dc; start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    chk($sformatf("busy_after_start[%0d]", g), 64'(busy[g]), 64'd1);
    wait_done(g, cyc);
    chk($sformatf("latency[%0d]", g), 64'(cyc), 64'(LAT_T[g]));
    chk($sformatf("result[%0d]", g), dout[g], exp_v);
    ack[g] = 1'b1;
    @(posedge clk); #1;
    ack[g] = 1'b0;
    chk($sformatf("done_after_ack[%0d]", g), 64'(done[g]), 64'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = '0; dec = '0; ack = '0;
    for (int g = 0; g < 5; g++) begin key[g] = '0; din[g] = '0; end

    chk("model_enc_v1", des_model(K1, P1, 1'b0), C1);
    chk("model_dec_v1", des_model(K1, C1, 1'b1), P1);
    chk("model_enc_v3", des_model(K3, P3, 1'b0), C3);
    chk("model_enc_zero", des_model('0, '0, 1'b0), CZ);

    repeat (2) @(posedge clk); #1;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rst_busy[%0d]", g), 64'(busy[g]), 64'd0);
      chk($sformatf("rst_done[%0d]", g), 64'(done[g]), 64'd0);
      chk($sformatf("rst_dout[%0d]", g), dout[g], 64'd0);
    end
    chk_en = 1;
    reset = 1'b0;

    for (int g = 0; g < 5; g++) begin
      run_op(g, K1, P1, 1'b0, C1);
      run_op(g, K1, C1, 1'b1, P1);
      run_op(g, K3, P3, 1'b0, C3);
      run_op(g, '0, '0, 1'b0, CZ);
    end

    // Inputs churn during ROUND: result must still be the first vector.
    @(posedge clk); #1;
    key[0] = K1; din[0] = P1; dec[0] = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      key[0] = ~key[0]; din[0] = {$urandom, $urandom}; dec[0] = ~dec[0]; start[0] = ~start[0];
      @(posedge clk); #1;
    end
    start[0] = 1'b0;
    wait_done(0, cyc);
    chk("toggle_latency", 64'(cyc), 64'd11);
    chk("toggle_result", dout[0], C1);

    start[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("hold_dout", dout[0], C1);
      chk("hold_done", 64'(done[0]), 64'd1);
    end

    ack[0] = 1'b1;
    @(posedge clk); #1;
    ack[0] = 1'b0; start[0] = 1'b0;
    chk("start_ack_done", 64'(done[0]), 64'd0);
    chk("start_ack_busy", 64'(busy[0]), 64'd0);
    @(posedge clk); #1;
    chk("start_ack_no_restart", 64'(busy[0]), 64'd0);
    chk("start_ack_dout", dout[0], C1);

    // Abort during round 7.
    key[0] = K1; din[0] = P1; dec[0] = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("pre_abort_busy", 64'(busy[0]), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_done", 64'(done[0]), 64'd0);
    chk("abort_dout", dout[0], 64'd0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    run_op(0, K1, P1, 1'b0, C1);

    repeat (2) @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
